boe_report: RTL and testbench
=============================

BOE_REPORT -- requirements
Module: boe_report

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset; the block is held in reset while rst=0.
REQ-003 SHALL have port start, input, 1 bit: marks the cycle in which result_in carries a group's sum word.
REQ-004 SHALL have port data_num, input, 3 bits: group size n, sampled only when start=1; legal range 1..6.
REQ-005 SHALL have port result_in, input, 11 bits: upstream word stream in a fixed order: sum, then min, then n sorted values, largest first.
REQ-006 SHALL have port out_ready, input, 1 bit: downstream accepts the report.
REQ-007 SHALL have port out_valid, output, 1 bit: report fields are valid.
REQ-008 SHALL have port sum_out, output, 11 bits: captured sum.
REQ-009 SHALL have port min_out, max_out, median_out, range_out, output, 8 bits each: statistics fields.
REQ-010 SHALL have port avg_q, output, 8 bits; avg_r, output, 3 bits: quotient and remainder of sum/n.
REQ-011 SHALL have port mismatch, output, 1 bit: consistency error flag for the report.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-014 SHALL implement the FSM states IDLE, GET_MIN, GET_SORT, DIV and HOLD.
REQ-015 IDLE, start=1 with data_num in 1..6 SHALL latch n and sum=result_in[10:0], then go to GET_MIN.
REQ-016 IDLE, start=1 with data_num=0 or 7 SHALL pulse err for one cycle and remain in IDLE.
REQ-017 GET_MIN SHALL capture result_in[7:0] as min_out, then go to GET_SORT, unconditionally after 1 cycle.
REQ-018 GET_SORT SHALL sample one word per cycle for exactly n cycles, using a 3-bit index 0..n-1.
REQ-019 In GET_SORT, index 0 SHALL be stored as max_out.
REQ-020 In GET_SORT, index floor((n-1)/2) SHALL be stored as median_out.
REQ-021 In GET_SORT, index n-1 SHALL be stored as the last value.
REQ-022 After index n-1, the FSM SHALL go to DIV.
REQ-023 In GET_SORT, any sorted word greater than its predecessor SHALL set mismatch.
REQ-024 mismatch SHALL also be set if the last value differs from min_out.
REQ-025 DIV SHALL be an iterative restoring divide of the 11-bit sum by the 3-bit n, one quotient bit per cycle, exactly 11 cycles.
REQ-026 After DIV completes, the FSM SHALL go to HOLD.
REQ-027 avg_q SHALL be the quotient saturated to 255, and avg_r the remainder.
REQ-028 range_out SHALL be max_out-min_out, computed on 8 bits; if max_out<min_out it SHALL be 0 and mismatch SHALL be set.
REQ-029 out_valid SHALL rise on the 12th rising edge after the edge that samples sorted index n-1.
REQ-030 In HOLD, out_valid=1 and all report fields SHALL stay stable until out_ready=1.
REQ-031 On an edge with out_valid=1 and out_ready=1, the FSM SHALL return to IDLE and deassert out_valid.
REQ-032 mismatch SHALL be cleared when the FSM returns to IDLE.
REQ-033 out_ready=1 before HOLD SHALL have no effect.
REQ-034 start=1 in any non-IDLE state, including the HOLD-exit cycle, SHALL pulse err and be ignored; the group is not captured.
REQ-035 data_num SHALL be ignored whenever start=0.
REQ-036 result_in bits [10:8] SHALL be ignored for min and sorted words.

Reset
REQ-037 rst=0 SHALL force state IDLE and out_valid=0, busy=0, err=0, mismatch=0.
REQ-038 rst=0 SHALL clear every report field (sum_out, min_out, max_out, median_out, range_out, avg_q, avg_r) and the internal index and divider registers to 0.
REQ-039 Assertion of rst mid-group (any state) SHALL abandon the group immediately.
REQ-040 After rst deasserts, out_valid SHALL not assert until a new legal start sequence completes.

Verification
REQ-041 SHALL drive n=4: words 280, 10, 200, 40, 30, 10 -> sum 280, min 10, max 200, median 40, range 190, avg_q 70, avg_r 0, mismatch 0.
REQ-042 SHALL drive n=6: words 265, 1, 250, 5, 4, 3, 2, 1 -> avg_q 44, avg_r 1, median 4, range 249.
REQ-043 SHALL drive n=1: words 9, 9, 9 -> max=min=median=9, range 0, avg_q 9, avg_r 0.
REQ-044 SHALL drive n=3 with sorted words 5, 7, 2 and min 2 -> mismatch 1.
REQ-045 SHALL hold out_ready=0 for 20 cycles in HOLD -> fields stable; then send a start during HOLD -> err pulse and no capture.
REQ-046 SHALL drive start with data_num=0 -> err 1 cycle, busy stays 0; and drive rst=0 during DIV -> all outputs 0 next cycle, out_valid stays 0.

Source files
------------

// File: rtl/boe_report.sv
// Group statistics reporter: captures sum, min and a descending sorted stream,
// divides sum by n iteratively and holds the report until downstream accepts it.
module boe_report (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  data_num,
  input  logic [10:0] result_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [10:0] sum_out,
  output logic [7:0]  min_out,
  output logic [7:0]  max_out,
  output logic [7:0]  median_out,
  output logic [7:0]  range_out,
  output logic [7:0]  avg_q,
  output logic [2:0]  avg_r,
  output logic        mismatch,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, GET_MIN, GET_SORT, DIV, HOLD} state_t;

  state_t      state, state_nxt;
  logic [2:0]  n_r, idx, med_idx;
  logic [7:0]  prev, last_r, word;
  logic [3:0]  rem, rem_sh, rem_nxt, cnt;
  logic [10:0] dvd;
  logic        start_ok, last_idx, div_done, hold_exit, rem_ge;

  assign word      = result_in[7:0];
  assign start_ok  = start && (state == IDLE) && (data_num != 3'd0) && (data_num != 3'd7);
  assign last_idx  = (idx == n_r - 3'd1);
  assign med_idx   = (n_r - 3'd1) >> 1;
  assign div_done  = (cnt == 4'd10);
  assign hold_exit = (state == HOLD) && out_valid && out_ready;
  assign busy      = (state != IDLE);

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh  = {rem[2:0], dvd[10]};
  assign rem_ge  = (rem_sh >= {1'b0, n_r});
  assign rem_nxt = rem_ge ? (rem_sh - {1'b0, n_r}) : rem_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_ok) state_nxt = GET_MIN;
      GET_MIN:  state_nxt = GET_SORT;
      GET_SORT: if (last_idx) state_nxt = DIV;
      DIV:      if (div_done) state_nxt = HOLD;
      HOLD:     if (hold_exit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_r        <= '0;
      idx        <= '0;
      prev       <= '0;
      last_r     <= '0;
      rem        <= '0;
      dvd        <= '0;
      cnt        <= '0;
      sum_out    <= '0;
      min_out    <= '0;
      max_out    <= '0;
      median_out <= '0;
      range_out  <= '0;
      avg_q      <= '0;
      avg_r      <= '0;
      mismatch   <= 1'b0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= start && !start_ok;
      case (state)
        IDLE: if (start_ok) begin
          n_r      <= data_num;
          sum_out  <= result_in;
          idx      <= '0;
          mismatch <= 1'b0;
        end
        GET_MIN: min_out <= word;
        GET_SORT: begin
          if (idx == 3'd0) max_out <= word;
          if (idx == med_idx) median_out <= word;
          if (idx != 3'd0 && word > prev) mismatch <= 1'b1;
          prev <= word;
          if (last_idx) begin
            last_r <= word;
            rem    <= '0;
            dvd    <= sum_out;
            cnt    <= '0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          dvd <= {dvd[9:0], rem_ge};
          cnt <= cnt + 4'd1;
        end
        HOLD: begin
          // First HOLD cycle finalises the report; out_valid rises on the next edge.
          if (!out_valid) begin
            out_valid <= 1'b1;
            avg_q     <= (|dvd[10:8]) ? 8'hFF : dvd[7:0];
            avg_r     <= rem[2:0];
            if (max_out >= min_out) range_out <= max_out - min_out;
            else                    range_out <= 8'd0;
            if (max_out < min_out || last_r != min_out) mismatch <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            mismatch  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boe_report.sv
// Directed bench for boe_report: hand-computed reports, HOLD stall, illegal
// starts and reset abandonment.
`timescale 1ns/1ps
module tb_boe_report;
  logic        clk, rst, start, out_ready;
  logic [2:0]  data_num;
  logic [10:0] result_in;
  logic        out_valid, mismatch, busy, err;
  logic [10:0] sum_out;
  logic [7:0]  min_out, max_out, median_out, range_out, avg_q;
  logic [2:0]  avg_r;
  logic [10:0] wv [6];
  int checks, errors;

  boe_report dut (
    .clk(clk), .rst(rst), .start(start), .data_num(data_num), .result_in(result_in),
    .out_ready(out_ready), .out_valid(out_valid), .sum_out(sum_out), .min_out(min_out),
    .max_out(max_out), .median_out(median_out), .range_out(range_out), .avg_q(avg_q),
    .avg_r(avg_r), .mismatch(mismatch), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_report(input string tag, input int s, mn, mx, md, rg, q, r, mm);
    chk({tag, " valid"}, out_valid, 1);
    chk({tag, " sum"}, sum_out, s);
    chk({tag, " min"}, min_out, mn);
    chk({tag, " max"}, max_out, mx);
    chk({tag, " median"}, median_out, md);
    chk({tag, " range"}, range_out, rg);
    chk({tag, " avg_q"}, avg_q, q);
    chk({tag, " avg_r"}, avg_r, r);
    chk({tag, " mismatch"}, mismatch, mm);
  endtask

  // Drives start/sum, min, then n sorted words; returns just after the edge sampling index n-1.
  task automatic feed(input logic [2:0] n, input logic [10:0] s, input logic [10:0] mn, input logic rdy);
    @(negedge clk); start = 1'b1; data_num = n; result_in = s; out_ready = rdy;
    @(negedge clk); start = 1'b0; data_num = 3'd7; result_in = mn;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); result_in = wv[i];
    end
    @(posedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < 40);
    chk({tag, " latency"}, lat, 12);
  endtask

  task automatic ack(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " ack valid"}, out_valid, 0);
    chk({tag, " ack busy"}, busy, 0);
    chk({tag, " ack mismatch"}, mismatch, 0);
    @(negedge clk); out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    checks = 0; errors = 0;
    rst = 1'b0; start = 1'b0; data_num = '0; result_in = '0; out_ready = 1'b0;
    #12;
    chk("reset state", {out_valid, busy, err, mismatch, sum_out, avg_q, range_out}, 0);
    @(negedge clk); rst = 1'b1;

    // n=4, min word carries junk in [10:8] that must be dropped
    wv = '{11'd200, 11'd40, 11'd30, 11'd10, 11'd0, 11'd0};
    feed(3'd4, 11'd280, 11'h70A, 1'b0);
    wait_valid("n4");
    chk_report("n4", 280, 10, 200, 40, 190, 70, 0, 0);
    ack("n4");

    // n=6 with out_ready held high throughout: no effect before HOLD
    wv = '{11'd250, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
    feed(3'd6, 11'd265, 11'd1, 1'b1);
    wait_valid("n6");
    chk_report("n6", 265, 1, 250, 4, 249, 44, 1, 0);
    ack("n6");

    wv = '{11'd9, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
    feed(3'd1, 11'd9, 11'd9, 1'b0);
    wait_valid("n1");
    chk_report("n1", 9, 9, 9, 9, 0, 9, 0, 0);
    ack("n1");

    // out-of-order sorted stream
    wv = '{11'd5, 11'd7, 11'd2, 11'd0, 11'd0, 11'd0};
    feed(3'd3, 11'd14, 11'd2, 1'b0);
    wait_valid("n3");
    chk_report("n3", 14, 2, 5, 7, 3, 4, 2, 1);
    ack("n3");

    // quotient saturation
    wv = '{11'd200, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
    feed(3'd1, 11'd2000, 11'd200, 1'b0);
    wait_valid("sat");
    chk_report("sat", 2000, 200, 200, 200, 0, 255, 0, 0);
    ack("sat");

    // max below min: range clamps to 0
    wv = '{11'd5, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0};
    feed(3'd1, 11'd5, 11'd9, 1'b0);
    wait_valid("neg");
    chk_report("neg", 5, 9, 5, 5, 0, 5, 0, 1);
    ack("neg");

    // HOLD stall, start during HOLD, start on HOLD-exit cycle
    wv = '{11'd200, 11'd100, 11'd0, 11'd0, 11'd0, 11'd0};
    feed(3'd2, 11'd300, 11'd100, 1'b0);
    wait_valid("n2");
    chk_report("n2", 300, 100, 200, 200, 100, 150, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("stall", {out_valid, sum_out, avg_q, range_out}, {1'b1, 11'd300, 8'd150, 8'd100});
    end
    @(negedge clk); start = 1'b1; data_num = 3'd3; result_in = 11'd77;
    @(posedge clk); #1;
    chk("hold start err", err, 1);
    chk("hold start sum", sum_out, 300);
    chk("hold start valid", {out_valid, busy}, 2'b11);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("err one cycle", err, 0);
    @(negedge clk); start = 1'b1; data_num = 3'd2; result_in = 11'd55; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("exit start err", err, 1);
    chk("exit valid", out_valid, 0);
    @(negedge clk); start = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("exit no capture", {busy, err}, 0);

    // illegal group sizes
    @(negedge clk); start = 1'b1; data_num = 3'd0;
    @(posedge clk); #1;
    chk("n0 err", {err, busy}, 2'b10);
    @(negedge clk); data_num = 3'd7;
    @(posedge clk); #1;
    chk("n7 err", {err, busy}, 2'b10);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("illegal err clear", {err, busy}, 0);

    // reset in the middle of DIV
    wv = '{11'd200, 11'd40, 11'd30, 11'd10, 11'd0, 11'd0};
    feed(3'd4, 11'd280, 11'd10, 1'b0);
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    #1;
    chk("rst div ctl", {out_valid, busy, err, mismatch}, 0);
    chk("rst div sum", sum_out, 0);
    chk("rst div fields", {min_out, max_out, median_out, avg_q}, 0);
    @(negedge clk); rst = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1; seen |= out_valid | busy;
    end
    chk("rst no valid", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
